// File: rtl/aftab_booth_controller.sv
// Sequencing FSM for the AFTAB AAU radix-2 Booth multiplier datapath.
// Optional abort input/path enabled by defining AFTAB_BOOTH_ABORT_EN.
module aftab_booth_controller #(
  parameter int size = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startBooth,
  input  logic [1:0] op,
`ifdef AFTAB_BOOTH_ABORT_EN
  input  logic       abortBooth,
`endif
  output logic       ldM,
  output logic       ldMr,
  output logic       zeroP,
  output logic       ldP,
  output logic       shrMr,
  output logic       sel,
  output logic       subsel,
  output logic       busy,
  output logic       doneBooth
);

  localparam int cw = $clog2(size) + 1;
  localparam logic [cw-1:0] last_count = cw'(size - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [cw-1:0] count_r;
  logic          count_clr_s;
  logic          count_inc_s;
  logic          abort_s;

`ifdef AFTAB_BOOTH_ABORT_EN
  assign abort_s = abortBooth;
`else
  assign abort_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Booth step counter: cleared on start/abort, advanced once per STEP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {cw{1'b0}};
    end else if (count_clr_s) begin
      count_r <= {cw{1'b0}};
    end else if (count_inc_s) begin
      count_r <= count_r + {{(cw-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state_s = state_r;
    count_clr_s  = 1'b0;
    count_inc_s  = 1'b0;
    ldM          = 1'b0;
    ldMr         = 1'b0;
    zeroP        = 1'b0;
    ldP          = 1'b0;
    shrMr        = 1'b0;
    sel          = 1'b0;
    subsel       = 1'b0;
    busy         = 1'b0;
    doneBooth    = 1'b0;
    case (state_r)
      IDLE: begin
        // an abort in IDLE blocks the start for that cycle
        if (startBooth && !abort_s) begin
          ldM          = 1'b1;
          ldMr         = 1'b1;
          zeroP        = 1'b1;
          count_clr_s  = 1'b1;
          next_state_s = STEP;
        end else begin
          next_state_s = IDLE;
        end
      end
      STEP: begin
        busy = 1'b1;
        if (abort_s) begin
          count_clr_s  = 1'b1;
          next_state_s = IDLE;
        end else begin
          ldP         = 1'b1;
          shrMr       = 1'b1;
          count_inc_s = 1'b1;
          case (op)
            2'b01: begin
              sel    = 1'b1;
              subsel = 1'b0;
            end
            2'b10: begin
              sel    = 1'b1;
              subsel = 1'b1;
            end
            default: begin
              sel    = 1'b0;
              subsel = 1'b0;
            end
          endcase
          if (count_r == last_count) begin
            next_state_s = DONE;
          end else begin
            next_state_s = STEP;
          end
        end
      end
      DONE: begin
        busy         = 1'b1;
        next_state_s = IDLE;
        if (abort_s) begin
          count_clr_s = 1'b1;
          doneBooth   = 1'b0;
        end else begin
          doneBooth = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule
